// File: rtl/led_ip_pkg.sv
// Shared constants, types and helpers for the LED AXI4-Lite register block.
package led_ip_pkg;

    // Register select values taken from ADDR[3:2]
    localparam logic [1:0] ADDR_LED_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL     = 2'd1;
    localparam logic [1:0] ADDR_PERIOD   = 2'd2;
    localparam logic [1:0] ADDR_SCRATCH  = 2'd3;

    // Bit positions inside the CTRL register
    localparam int CTRL_BLINK_BIT  = 0;
    localparam int CTRL_ROTATE_BIT = 1;

    // The block never signals an error response
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic rotate;
        logic blink;
    } led_ctrl_t;

    // Merge new write data into an old register value, byte lane by byte lane
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // Pull the control flags out of the low bits of CTRL
    function automatic led_ctrl_t decode_ctrl(input logic [1:0] ctrl_bits);
        led_ctrl_t c;
        c.blink  = ctrl_bits[CTRL_BLINK_BIT];
        c.rotate = ctrl_bits[CTRL_ROTATE_BIT];
        return c;
    endfunction

endpackage

// File: rtl/led_axil_regs_if.sv
// AXI4-Lite bus bundle between the VIP master and the LED register slave.
interface led_axil_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine: tick counter, rotating pattern, blink phase and the
// registered LED drive.
module led_pattern_engine
    import led_ip_pkg::*;
#(
    parameter int NUM_LEDS = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_LEDS-1:0] pattern_i,
    input  led_ctrl_t           ctrl_i,
    input  logic [31:0]         period_i,
    input  logic                load_i,
    input  logic                period_wr_i,
    output logic [NUM_LEDS-1:0] led_o
);

    logic [31:0]         cnt_q, cnt_d;
    logic [NUM_LEDS-1:0] pat_q, pat_d;
    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [31:0]         period_eff_s;
    logic                tick_s;

    // Rotate left by one; written as a loop so a single LED is also legal
    function automatic logic [NUM_LEDS-1:0] rotl1(input logic [NUM_LEDS-1:0] v);
        logic [NUM_LEDS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            r[(i + 1) % NUM_LEDS] = v[i];
        end
        return r;
    endfunction

    // Tick generation: a PERIOD of zero behaves as one
    always_comb begin
        period_eff_s = period_i;
        tick_s       = 1'b0;
        if (period_i == 32'd0) begin
            period_eff_s = 32'd1;
        end else begin
            period_eff_s = period_i;
        end
        tick_s = (cnt_q == (period_eff_s - 32'd1));
    end

    // Next state of counter, pattern, phase and LED
    always_comb begin
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        phase_d = phase_q;
        led_d   = pat_q & ~{NUM_LEDS{phase_q}};

        if (period_wr_i || tick_s) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        // A register reload wins over a tick landing on the same edge
        if (load_i) begin
            pat_d = pattern_i;
        end else if (tick_s && ctrl_i.rotate) begin
            pat_d = rotl1(pat_q);
        end else begin
            pat_d = pat_q;
        end

        if (tick_s) begin
            if (ctrl_i.blink) begin
                phase_d = ~phase_q;
            end else begin
                phase_d = 1'b0;
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Engine state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 32'd0;
            pat_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_axil_regs.sv
// AXI4-Lite slave with four 32-bit RW registers driving the LED pattern engine.
module led_axil_regs
    import led_ip_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_LEDS           = 8,
    parameter int PERIOD_RESET       = 50
) (
    input  logic                ACLK,
    input  logic                ARESET,
    led_axil_regs_if.slave      s_axi,
    output logic [NUM_LEDS-1:0] LED
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    // Register file
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];

    // Write channel state
    logic                          aw_got_q, aw_got_d;
    logic                          w_got_q, w_got_d;
    logic [1:0]                    awsel_q, awsel_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]             wstrb_q, wstrb_d;
    logic                          bvalid_q, bvalid_d;

    // Read channel state
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Combinational handshake terms
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_s, araddr_s;
    logic                          awready_s, wready_s, arready_s;
    logic                          aw_hs_s, w_hs_s, ar_hs_s;
    logic                          b_done_s, r_done_s, do_write_s;
    logic [1:0]                    wsel_s;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data_s;
    logic [STRB_W-1:0]             wr_strb_s;
    logic                          load_s, period_wr_s;
    logic [NUM_LEDS-1:0]           led_pattern_s;
    led_ctrl_t                     ctrl_s;
    logic                          unused_ok_s;

    assign awaddr_s = s_axi.S_AXI_AWADDR;
    assign araddr_s = s_axi.S_AXI_ARADDR;

    // Ready/handshake decode and selection of captured versus live write fields
    always_comb begin
        awready_s  = !aw_got_q && !bvalid_q;
        wready_s   = !w_got_q && !bvalid_q;
        arready_s  = !rvalid_q;
        aw_hs_s    = s_axi.S_AXI_AWVALID && awready_s;
        w_hs_s     = s_axi.S_AXI_WVALID && wready_s;
        ar_hs_s    = s_axi.S_AXI_ARVALID && arready_s;
        b_done_s   = bvalid_q && s_axi.S_AXI_BREADY;
        r_done_s   = rvalid_q && s_axi.S_AXI_RREADY;
        do_write_s = (aw_got_q || aw_hs_s) && (w_got_q || w_hs_s) && !bvalid_q;

        if (aw_got_q) begin
            wsel_s = awsel_q;
        end else begin
            wsel_s = awaddr_s[3:2];
        end

        if (w_got_q) begin
            wr_data_s = wdata_q;
            wr_strb_s = wstrb_q;
        end else begin
            wr_data_s = s_axi.S_AXI_WDATA;
            wr_strb_s = s_axi.S_AXI_WSTRB;
        end
    end

    // Write channel flags, captured fields and response valid
    always_comb begin
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        awsel_d  = awsel_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;

        if (b_done_s) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            bvalid_d = 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_got_d = 1'b1;
                awsel_d  = awaddr_s[3:2];
            end else begin
                aw_got_d = aw_got_q;
            end
            if (w_hs_s) begin
                w_got_d = 1'b1;
                wdata_d = s_axi.S_AXI_WDATA;
                wstrb_d = s_axi.S_AXI_WSTRB;
            end else begin
                w_got_d = w_got_q;
            end
            if (do_write_s) begin
                bvalid_d = 1'b1;
            end else begin
                bvalid_d = bvalid_q;
            end
        end
    end

    // Register file update with byte strobes
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
            if (do_write_s && (wsel_s == i[1:0])) begin
                regs_d[i] = apply_wstrb(regs_q[i], wr_data_s, wr_strb_s);
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Read channel: latch data on AR handshake, hold until RREADY
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[araddr_s[3:2]];
        end else if (r_done_s) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Engine controls; the new LED_DATA value is handed over on the write edge
    always_comb begin
        load_s        = do_write_s && ((wsel_s == ADDR_LED_DATA) || (wsel_s == ADDR_CTRL));
        period_wr_s   = do_write_s && (wsel_s == ADDR_PERIOD);
        led_pattern_s = regs_d[ADDR_LED_DATA][NUM_LEDS-1:0];
        ctrl_s        = decode_ctrl(regs_q[ADDR_CTRL][1:0]);
    end

    // Bus and register state with synchronous reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q[ADDR_LED_DATA] <= 32'd0;
            regs_q[ADDR_CTRL]     <= 32'd0;
            regs_q[ADDR_PERIOD]   <= 32'(PERIOD_RESET);
            regs_q[ADDR_SCRATCH]  <= 32'd0;
            aw_got_q              <= 1'b0;
            w_got_q               <= 1'b0;
            awsel_q               <= 2'd0;
            wdata_q               <= 32'd0;
            wstrb_q               <= '0;
            bvalid_q              <= 1'b0;
            rvalid_q              <= 1'b0;
            rdata_q               <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            awsel_q  <= awsel_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    led_pattern_engine #(
        .NUM_LEDS (NUM_LEDS)
    ) u_engine (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .pattern_i   (led_pattern_s),
        .ctrl_i      (ctrl_s),
        .period_i    (regs_q[ADDR_PERIOD]),
        .load_i      (load_s),
        .period_wr_i (period_wr_s),
        .led_o       (LED)
    );

    assign s_axi.S_AXI_AWREADY = awready_s;
    assign s_axi.S_AXI_WREADY  = wready_s;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = arready_s;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    // Byte-offset address bits and PROT are intentionally ignored
    assign unused_ok_s = ^{awaddr_s, araddr_s, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

endmodule

// File: tb/tb_led_axil_regs.sv
// Directed bench for led_axil_regs: register table, split AW/W, strobes,
// back-pressure, LED rotate/blink sequences and mid-transaction reset.
module tb_led_axil_regs;
    import led_ip_pkg::*;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic [7:0] LED;

    led_axil_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    led_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .NUM_LEDS           (8),
        .PERIOD_RESET       (50)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (bus.slave),
        .LED    (LED)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] samp [24];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit got;
        got = 1'b0;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge ACLK);
            if (bus.S_AXI_BVALID) got = 1'b1;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (!got) check("write bvalid timeout", 32'd0, 32'd1);
        else check("bresp", 32'(bus.S_AXI_BRESP), 32'(RESP_OKAY));
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit got;
        got = 1'b0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge ACLK);
            if (bus.S_AXI_RVALID) got = 1'b1;
        end
        bus.S_AXI_ARVALID = 1'b0;
        data = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        if (!got) check("read rvalid timeout", 32'd0, 32'd1);
    endtask

    task automatic read_check(input string nm, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check(nm, d, exp);
        check({nm, " rresp"}, 32'(r), 32'(RESP_OKAY));
    endtask

    // AW and W separated by three cycles in either order; one response expected
    task automatic split_write(input bit aw_first, input logic [3:0] addr, input logic [31:0] data);
        int bcount;
        bcount = 0;
        @(negedge ACLK);
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = 4'hF;
        if (aw_first) bus.S_AXI_AWVALID = 1'b1;
        else bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (aw_first) check("split awready low while held", 32'(bus.S_AXI_AWREADY), 32'd0);
        else check("split wready low while held", 32'(bus.S_AXI_WREADY), 32'd0);
        bcount += int'(bus.S_AXI_BVALID);
        repeat (2) begin
            @(negedge ACLK);
            bcount += int'(bus.S_AXI_BVALID);
        end
        if (aw_first) bus.S_AXI_WVALID = 1'b1;
        else bus.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        check("split bvalid after later handshake", 32'(bus.S_AXI_BVALID), 32'd1);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bcount += int'(bus.S_AXI_BVALID);
        repeat (5) begin
            @(negedge ACLK);
            bcount += int'(bus.S_AXI_BVALID);
        end
        check("split single bvalid", 32'(bcount), 32'd1);
        read_check("split readback", addr, data);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            samp[i] = LED;
            @(negedge ACLK);
        end
    endtask

    // samp[0] is v0, the first change lands in kmin..kmax, then runs of per samples e1,e2,e3
    task automatic check_seq(input string nm, input logic [7:0] v0, input int kmin, input int kmax,
                             input int per, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        int k;
        logic [7:0] e;
        k = 0;
        check({nm, " start"}, 32'(samp[0]), 32'(v0));
        for (int i = 1; i < 24; i++) begin
            if (k == 0 && samp[i] != samp[0]) k = i;
        end
        n_checks++;
        if (k >= kmin && k <= kmax) n_pass++;
        else $display("FAIL %s first step: index %0d, expected %0d..%0d", nm, k, kmin, kmax);
        if (k >= kmin && k <= kmax && (k + 3 * per) <= 24) begin
            for (int m = 0; m < 3 * per; m++) begin
                if (m < per) e = e1;
                else if (m < 2 * per) e = e2;
                else e = e3;
                check($sformatf("%s step %0d", nm, m), 32'(samp[k + m]), 32'(e));
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          bcount;

        bus.S_AXI_AWADDR  = 4'h0;
        bus.S_AXI_AWPROT  = 3'b000;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = 32'd0;
        bus.S_AXI_WSTRB   = 4'h0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = 4'h0;
        bus.S_AXI_ARPROT  = 3'b000;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;

        tbl[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        tbl[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        tbl[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
        tbl[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
        tbl[4] = '{4'hC, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
        tbl[5] = '{4'hC, 32'h1122_3344, 4'h5, 32'hDE22_BE44};
        tbl[6] = '{4'hC, 32'hFFFF_FFFF, 4'h0, 32'hDE22_BE44};
        tbl[7] = '{4'hC, 32'h5566_7788, 4'hA, 32'h5522_7744};

        // Reset state
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        check("reset bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        check("reset rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
        check("reset rdata", bus.S_AXI_RDATA, 32'd0);
        check("reset led", 32'(LED), 32'd0);
        check("reset awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        check("reset wready", 32'(bus.S_AXI_WREADY), 32'd1);
        check("reset arready", 32'(bus.S_AXI_ARREADY), 32'd1);
        read_check("reset LED_DATA", 4'h0, 32'd0);
        read_check("reset CTRL", 4'h4, 32'd0);
        read_check("reset PERIOD", 4'h8, 32'd50);
        read_check("reset SCRATCH", 4'hC, 32'd0);

        // Register table: write then read back each entry
        for (int i = 0; i < 8; i++) begin
            axi_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
            read_check($sformatf("table %0d", i), tbl[i].addr, tbl[i].exp);
        end
        read_check("final LED_DATA", 4'h0, 32'd1);
        read_check("final CTRL", 4'h4, 32'd2);
        read_check("final PERIOD", 4'h8, 32'd3);
        read_check("final SCRATCH", 4'hC, 32'h5522_7744);

        // Split AW/W in both orders
        split_write(1'b1, 4'hC, 32'h1234_5678);
        split_write(1'b0, 4'hC, 32'h0BAD_F00D);

        // Byte strobe plus B back-pressure
        axi_write(4'hC, 32'd0, 4'hF);
        @(negedge ACLK);
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_AWADDR  = 4'hC;
        bus.S_AXI_WDATA   = 32'hAABB_CCDD;
        bus.S_AXI_WSTRB   = 4'b0010;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
            check($sformatf("bp bvalid held %0d", i), 32'(bus.S_AXI_BVALID), 32'd1);
            check($sformatf("bp awready low %0d", i), 32'(bus.S_AXI_AWREADY), 32'd0);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        check("bp bvalid cleared", 32'(bus.S_AXI_BVALID), 32'd0);
        check("bp awready back", 32'(bus.S_AXI_AWREADY), 32'd1);
        read_check("strobe readback", 4'hC, 32'h0000_CC00);

        // Read and write to SCRATCH on the same edge: read sees the old value
        @(negedge ACLK);
        bus.S_AXI_AWADDR  = 4'hC;
        bus.S_AXI_WDATA   = 32'h0000_0077;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARADDR  = 4'hC;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        check("same-cycle rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
        check("same-cycle old data", bus.S_AXI_RDATA, 32'h0000_CC00);
        check("same-cycle bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        read_check("same-cycle new data", 4'hC, 32'h0000_0077);

        // Rotate with PERIOD=2, then PERIOD=0
        axi_write(4'h4, 32'd0, 4'hF);
        axi_write(4'h8, 32'd2, 4'hF);
        axi_write(4'h0, 32'h81, 4'hF);
        axi_write(4'h4, 32'd2, 4'hF);
        capture(24);
        check_seq("rotate p2", 8'h81, 2, 3, 2, 8'h03, 8'h06, 8'h0C);
        axi_write(4'h8, 32'd0, 4'hF);
        capture(12);
        for (int m = 1; m < 10; m++) begin
            check($sformatf("rotate p0 step %0d", m), 32'(samp[m + 1]), 32'(rotl8(samp[m])));
        end

        // Blink with PERIOD=4, then blink off holds the pattern
        axi_write(4'h4, 32'd0, 4'hF);
        axi_write(4'h8, 32'd4, 4'hF);
        axi_write(4'h0, 32'hF0, 4'hF);
        axi_write(4'h4, 32'd1, 4'hF);
        capture(24);
        check_seq("blink p4", 8'hF0, 2, 5, 4, 8'h00, 8'hF0, 8'h00);
        axi_write(4'h4, 32'd0, 4'hF);
        repeat (6) @(negedge ACLK);
        capture(8);
        for (int m = 0; m < 8; m++) begin
            check($sformatf("blink off hold %0d", m), 32'(samp[m]), 32'h0000_00F0);
        end

        // Reset with a captured AW and a pending read response
        check("pre-reset led", 32'(LED), 32'h0000_00F0);
        bus.S_AXI_AWADDR  = 4'h8;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_ARADDR  = 4'h8;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        bus.S_AXI_BREADY  = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        check("pre-reset rvalid pending", 32'(bus.S_AXI_RVALID), 32'd1);
        check("pre-reset awready low", 32'(bus.S_AXI_AWREADY), 32'd0);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check("mid reset bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        check("mid reset rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
        check("mid reset led", 32'(LED), 32'd0);
        check("mid reset awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        bus.S_AXI_WDATA  = 32'h0000_0009;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_WVALID = 1'b0;
        bcount = int'(bus.S_AXI_BVALID);
        repeat (3) begin
            @(negedge ACLK);
            bcount += int'(bus.S_AXI_BVALID);
        end
        check("dropped AW gives no response", 32'(bcount), 32'd0);
        read_check("mid reset PERIOD", 4'h8, 32'd50);
        check("mid reset led stays", 32'(LED), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
